// File: rtl/chdr_pkg.sv
// Shared CHDR definitions for the sc16 -> sc8 narrowing converter.
//   - CHDR header field positions (packet length, has_time flag)
//   - header byte counts with and without a timestamp word
//   - converter state encoding
//   - chdr_narrow_len(): rewrites the packet length for halved payload
package chdr_pkg;

  localparam int unsigned CHDR_LEN_MSB      = 47;
  localparam int unsigned CHDR_LEN_LSB      = 32;
  localparam int unsigned CHDR_HAS_TIME_BIT = 61;

  localparam logic [15:0] CHDR_HDR_BYTES      = 16'd8;
  localparam logic [15:0] CHDR_HDR_TIME_BYTES = 16'd16;

  typedef enum logic [1:0] {
    ST_HEADER = 2'd0,
    ST_TIME   = 2'd1,
    ST_FIRST  = 2'd2,
    ST_SECOND = 2'd3
  } state_t;

  // Header bytes are kept, payload bytes are halved; arithmetic wraps at 16 bits.
  function automatic logic [15:0] chdr_narrow_len(input logic [15:0] len,
                                                  input logic        has_time);
    logic [15:0] hdr_bytes;
    logic [15:0] payload;
    hdr_bytes = has_time ? CHDR_HDR_TIME_BYTES : CHDR_HDR_BYTES;
    payload   = len - hdr_bytes;
    return hdr_bytes + (payload >> 1);
  endfunction

endpackage

// File: rtl/chdr_16sc_to_8sc_sample.sv
// sc16_to_sc8_sample: narrows one 32-bit sc16 I/Q pair to a 16-bit sc8 pair.
// Component k (i_pair[16k+15:16k]) becomes byte k (o_pair[8k+7:8k]).
//   Build option CHDR_16SC_TO_8SC_ROUND_EN:
//     defined   : round half up ((c+128)>>>8) and clamp to [-128,127]
//     undefined : truncate to c[15:8]
// Purely combinational.
module sc16_to_sc8_sample (
  input  logic [31:0] i_pair,
  output logic [15:0] o_pair
);

  for (genvar g = 0; g < 2; g++) begin : g_comp
`ifdef CHDR_16SC_TO_8SC_ROUND_EN
    logic signed [16:0] biased;
    logic signed [16:0] shifted;
    assign biased  = $signed({i_pair[16*g+15], i_pair[16*g +: 16]}) + 17'sd128;
    assign shifted = biased >>> 8;
    // Only the top end can actually overflow (max 128), but clamp both ways.
    assign o_pair[8*g +: 8] = (shifted > 17'sd127)  ? 8'h7F :
                              (shifted < -17'sd128) ? 8'h80 :
                                                      shifted[7:0];
`else
    assign o_pair[8*g +: 8] = i_pair[16*g+8 +: 8];
`endif
  end

`ifndef CHDR_16SC_TO_8SC_ROUND_EN
  logic unused_lsbs;
  assign unused_lsbs = ^{i_pair[23:16], i_pair[7:0]};
`endif

endmodule

// File: rtl/setting_reg.sv
// Settings-bus register: captures din[width-1:0] when strobe is high and
// addr matches my_addr.
//   clk, reset (async, active-low), strobe, addr[7:0], din[31:0]
//   out[width-1:0] : registered setting, at_reset after reset
module setting_reg #(
  parameter logic [7:0]       my_addr  = 8'd0,
  parameter int unsigned      width    = 32,
  parameter logic [width-1:0] at_reset = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             strobe,
  input  logic [7:0]       addr,
  input  logic [31:0]      din,
  output logic [width-1:0] out
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out <= at_reset;
    end else if (strobe && (addr == my_addr)) begin
      out <= din[width-1:0];
    end
  end

  if (width < 32) begin : g_unused
    logic unused_din_hi;
    assign unused_din_hi = ^din[31:width];
  end

endmodule

// File: rtl/chdr_16sc_to_8sc.sv
// chdr_16sc_to_8sc: streaming CHDR converter, sc16 payload -> sc8 payload.
// Two sc16 payload lines are packed into one sc8 output line; the header
// length is rewritten and the SID destination may be replaced.
//   clk, reset (async, active-low)
//   set_stb/set_addr/set_data : settings bus; register at BASE holds
//                               {set_sid, new_dest[15:0]}
//   i_t*  : sc16 CHDR input stream
//   o_t*  : sc8 CHDR output stream
//   debug : {28'h0, hold_valid, 1'b0, state[1:0]}
// Build option CHDR_16SC_TO_8SC_ROUND_EN selects rounding+saturation
// instead of truncation in the sample converter.
module chdr_16sc_to_8sc
  import chdr_pkg::*;
#(
  parameter int unsigned BASE = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [63:0] i_tdata,
  input  logic        i_tlast,
  input  logic        i_tvalid,
  output logic        i_tready,
  output logic [63:0] o_tdata,
  output logic        o_tlast,
  output logic        o_tvalid,
  input  logic        o_tready,
  output logic [31:0] debug
);

  state_t      state, state_nxt;
  logic [31:0] hold;
  logic        hold_valid;
  logic        hold_load;
  logic        hold_clr;
  logic [16:0] sid_cfg;
  logic [31:0] conv_word;
  logic [31:0] sid_field;
  logic [15:0] new_len;
  logic        has_time;
  logic        handshake;

  setting_reg #(
    .my_addr(8'(BASE)),
    .width  (17)
  ) sr_sid (
    .clk   (clk),
    .reset (reset),
    .strobe(set_stb),
    .addr  (set_addr),
    .din   (set_data),
    .out   (sid_cfg)
  );

  sc16_to_sc8_sample u_conv_lo (
    .i_pair(i_tdata[31:0]),
    .o_pair(conv_word[15:0])
  );

  sc16_to_sc8_sample u_conv_hi (
    .i_pair(i_tdata[63:32]),
    .o_pair(conv_word[31:16])
  );

  assign has_time  = i_tdata[CHDR_HAS_TIME_BIT];
  assign new_len   = chdr_narrow_len(i_tdata[CHDR_LEN_MSB:CHDR_LEN_LSB], has_time);
  assign sid_field = sid_cfg[16] ? {i_tdata[15:0], sid_cfg[15:0]} : i_tdata[31:0];
  assign handshake = i_tvalid && o_tready;
  assign debug     = {28'h0, hold_valid, 1'b0, state};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_HEADER;
      hold       <= '0;
      hold_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (hold_load) begin
        hold       <= conv_word;
        hold_valid <= 1'b1;
      end else if (hold_clr) begin
        hold_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    o_tdata   = i_tdata;
    o_tvalid  = i_tvalid;
    o_tlast   = i_tlast;
    i_tready  = o_tready;
    hold_load = 1'b0;
    hold_clr  = 1'b0;
    case (state)
      ST_HEADER: begin
        o_tdata = {i_tdata[63:48], new_len, sid_field};
        if (handshake) begin
          state_nxt = i_tlast ? ST_HEADER : (has_time ? ST_TIME : ST_FIRST);
        end
      end
      ST_TIME: begin
        if (handshake) begin
          state_nxt = i_tlast ? ST_HEADER : ST_FIRST;
        end
      end
      ST_FIRST: begin
        o_tdata = {conv_word, 32'h0};
        if (!i_tlast) begin
          // First half of a pair is absorbed regardless of downstream ready.
          i_tready = 1'b1;
          o_tvalid = 1'b0;
          o_tlast  = 1'b0;
          if (i_tvalid) begin
            hold_load = 1'b1;
            state_nxt = ST_SECOND;
          end
        end else begin
          o_tlast = 1'b1;
          if (handshake) begin
            state_nxt = ST_HEADER;
          end
        end
      end
      ST_SECOND: begin
        o_tdata = {hold, conv_word};
        if (handshake) begin
          hold_clr  = 1'b1;
          state_nxt = i_tlast ? ST_HEADER : ST_FIRST;
        end
      end
      default: state_nxt = ST_HEADER;
    endcase
  end

endmodule

// File: tb/tb_chdr_16sc_to_8sc.sv
module tb_chdr_16sc_to_8sc;

  logic        clk      = 1'b0;
  logic        reset    = 1'b0;
  logic        set_stb  = 1'b0;
  logic [7:0]  set_addr = '0;
  logic [31:0] set_data = '0;
  logic [63:0] i_tdata  = '0;
  logic        i_tlast  = 1'b0;
  logic        i_tvalid = 1'b0;
  logic        i_tready;
  logic [63:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready = 1'b0;
  logic [31:0] debug;

  localparam logic [7:0] SET_BASE = 8'd5;

  chdr_16sc_to_8sc #(.BASE(5)) dut (
    .clk     (clk),
    .reset   (reset),
    .set_stb (set_stb),
    .set_addr(set_addr),
    .set_data(set_data),
    .i_tdata (i_tdata),
    .i_tlast (i_tlast),
    .i_tvalid(i_tvalid),
    .i_tready(i_tready),
    .o_tdata (o_tdata),
    .o_tlast (o_tlast),
    .o_tvalid(o_tvalid),
    .o_tready(o_tready),
    .debug   (debug)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  bit          m_sid_on = 1'b0;
  logic [15:0] m_dest   = '0;

  typedef struct packed {logic last; logic [63:0] data;} beat_t;
  typedef struct packed {logic [63:0] din; logic last; logic [63:0] exp;} hdr_vec_t;
  typedef struct packed {logic [15:0] c16; logic [7:0] exp_rnd; logic [7:0] exp_trn;} conv_vec_t;

  beat_t in_q[$];
  beat_t exp_q[$];
  beat_t got_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] m_conv8(input logic [15:0] c);
`ifdef CHDR_16SC_TO_8SC_ROUND_EN
    int v, t, r;
    v = int'($signed(c));
    t = v + 128;
    r = (t >= 0) ? t / 256 : -((-t + 255) / 256);
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r[7:0];
`else
    return c[15:8];
`endif
  endfunction

  function automatic logic [31:0] m_conv32(input logic [63:0] w);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = m_conv8(w[16*k +: 16]);
    return r;
  endfunction

  function automatic logic [63:0] m_hdr(input logic [63:0] h);
    int hb, len, nl;
    logic [31:0] sid;
    hb  = h[61] ? 16 : 8;
    len = int'(h[47:32]);
    nl  = (hb + (((len - hb) & 32'hFFFF) / 2)) & 32'hFFFF;
    sid = m_sid_on ? {h[15:0], m_dest} : h[31:0];
    return {h[63:48], nl[15:0], sid};
  endfunction

  task automatic add_packet(input logic [63:0] hdr, input logic [63:0] tw, input logic [63:0] pl[$]);
    bit t;
    int n;
    t = hdr[61];
    n = pl.size();
    in_q.push_back({(!t && n == 0), hdr});
    exp_q.push_back({(!t && n == 0), m_hdr(hdr)});
    if (t) begin
      in_q.push_back({(n == 0), tw});
      exp_q.push_back({(n == 0), tw});
    end
    for (int k = 0; k < n; k += 2) begin
      in_q.push_back({(k == n - 1), pl[k]});
      if (k + 1 < n) begin
        in_q.push_back({(k + 1 == n - 1), pl[k+1]});
        exp_q.push_back({(k + 1 == n - 1), m_conv32(pl[k]), m_conv32(pl[k+1])});
      end else begin
        exp_q.push_back({1'b1, m_conv32(pl[k]), 32'h0});
      end
    end
  endtask

  task automatic add_random_packet();
    bit          t;
    int          n;
    logic [15:0] top;
    logic [15:0] len;
    logic [63:0] pl[$];
    t   = 1'($urandom_range(0, 1));
    n   = int'($urandom_range(0, 5));
    top = 16'($urandom);
    top[13] = t;
    len = 16'((t ? 16 : 8) + 8 * n);
    for (int k = 0; k < n; k++) pl.push_back({$urandom, $urandom});
    add_packet({top, len, $urandom}, {$urandom, $urandom}, pl);
  endtask

  // Drives in_q, collects output beats, compares against exp_q.
  task automatic run_stream(input bit rnd);
    int idx = 0;
    int cyc = 0;
    got_q.delete();
    while ((idx < in_q.size() || got_q.size() < exp_q.size()) && cyc < 4000) begin
      @(posedge clk); #1;
      o_tready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (idx < in_q.size() && (!rnd || $urandom_range(0, 3) != 0)) begin
        i_tvalid = 1'b1;
        i_tdata  = in_q[idx].data;
        i_tlast  = in_q[idx].last;
      end else begin
        i_tvalid = 1'b0;
        i_tdata  = {$urandom, $urandom};
        i_tlast  = 1'b0;
      end
      @(negedge clk);
      if (o_tvalid && o_tready) got_q.push_back({o_tlast, o_tdata});
      if (i_tvalid && i_tready) idx++;
      cyc++;
    end
    @(posedge clk); #1;
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    o_tready = 1'b0;
    check("beat_count", 64'(got_q.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      check($sformatf("beat%0d_data", k), got_q[k].data, exp_q[k].data);
      check($sformatf("beat%0d_last", k), 64'(got_q[k].last), 64'(exp_q[k].last));
    end
    @(negedge clk);
    check("idle_debug", 64'(debug), 64'h0);
    in_q.delete();
    exp_q.delete();
  endtask

  task automatic write_set(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    set_stb  = 1'b1;
    set_addr = a;
    set_data = d;
    @(posedge clk); #1;
    set_stb  = 1'b0;
  endtask

  task automatic check_hdr_static(input string name, input logic [63:0] din, input logic [63:0] exp);
    @(posedge clk); #1;
    i_tdata  = din;
    i_tlast  = 1'b0;
    i_tvalid = 1'b1;
    o_tready = 1'b0;
    @(negedge clk);
    check(name, o_tdata, exp);
  endtask

  initial begin
    hdr_vec_t    hv[6];
    conv_vec_t   cv[10];
    logic [63:0] pl[$];
    logic [63:0] p1, p2, w;
    logic [31:0] e32;
    int          lane;

    hv[0] = '{din: 64'h0000_0018_1234_5678, last: 1'b0, exp: 64'h0000_0010_1234_5678};
    hv[1] = '{din: 64'h1000_0020_0000_0001, last: 1'b1, exp: 64'h1000_0014_0000_0001};
    hv[2] = '{din: 64'h2000_0020_AAAA_BBBB, last: 1'b0, exp: 64'h2000_0018_AAAA_BBBB};
    hv[3] = '{din: 64'h0000_0008_0000_0000, last: 1'b1, exp: 64'h0000_0008_0000_0000};
    hv[4] = '{din: 64'hC000_0004_0000_0000, last: 1'b0, exp: 64'hC000_8006_0000_0000};
    hv[5] = '{din: 64'h2000_0110_DEAD_BEEF, last: 1'b1, exp: 64'h2000_0090_DEAD_BEEF};

    cv[0] = '{c16: 16'h7FF0, exp_rnd: 8'h7F, exp_trn: 8'h7F};
    cv[1] = '{c16: 16'h0180, exp_rnd: 8'h02, exp_trn: 8'h01};
    cv[2] = '{c16: 16'hFF80, exp_rnd: 8'h00, exp_trn: 8'hFF};
    cv[3] = '{c16: 16'h8000, exp_rnd: 8'h80, exp_trn: 8'h80};
    cv[4] = '{c16: 16'h007F, exp_rnd: 8'h00, exp_trn: 8'h00};
    cv[5] = '{c16: 16'h0080, exp_rnd: 8'h01, exp_trn: 8'h00};
    cv[6] = '{c16: 16'hFF7F, exp_rnd: 8'hFF, exp_trn: 8'hFF};
    cv[7] = '{c16: 16'h7F80, exp_rnd: 8'h7F, exp_trn: 8'h7F};
    cv[8] = '{c16: 16'h1234, exp_rnd: 8'h12, exp_trn: 8'h12};
    cv[9] = '{c16: 16'hABCD, exp_rnd: 8'hAC, exp_trn: 8'hAB};

    // Reset state: HEADER, outputs combinational from inputs.
    i_tdata  = 64'h0000_0018_1234_5678;
    i_tvalid = 1'b1;
    o_tready = 1'b1;
    #12;
    check("rst_debug", 64'(debug), 64'h0);
    check("rst_o_tdata", o_tdata, 64'h0000_0010_1234_5678);
    check("rst_i_tready", 64'(i_tready), 64'h1);
    check("rst_o_tvalid", 64'(o_tvalid), 64'h1);
    i_tvalid = 1'b0;
    o_tready = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Header rewrite table (no handshake: o_tready low).
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      i_tdata  = hv[i].din;
      i_tlast  = hv[i].last;
      i_tvalid = 1'b1;
      o_tready = 1'b0;
      @(negedge clk);
      check($sformatf("hdr%0d_data", i), o_tdata, hv[i].exp);
      check($sformatf("hdr%0d_last", i), 64'(o_tlast), 64'(hv[i].last));
      check($sformatf("hdr%0d_valid", i), 64'(o_tvalid), 64'h1);
      check($sformatf("hdr%0d_ready", i), 64'(i_tready), 64'h0);
    end

    // SID rewrite: correct address, wrong address, then disable.
    write_set(SET_BASE, 32'h0001_ABCD);
    check_hdr_static("sid_on", 64'h0000_0018_1234_5678, 64'h0000_0010_5678_ABCD);
    write_set(SET_BASE - 8'd1, 32'h0000_0000);
    check_hdr_static("sid_wrong_addr", 64'h0000_0018_1234_5678, 64'h0000_0010_5678_ABCD);
    write_set(SET_BASE, 32'h0000_0000);
    check_hdr_static("sid_off", 64'h0000_0018_1234_5678, 64'h0000_0010_1234_5678);

    // Conversion table, sampled in FIRST with tlast held (stalled).
    @(posedge clk); #1;
    i_tdata  = 64'h0000_0028_0000_0000;
    i_tlast  = 1'b0;
    i_tvalid = 1'b1;
    o_tready = 1'b1;
    @(posedge clk); #1;
    check("first_debug", 64'(debug), 64'h2);
    o_tready = 1'b0;
    i_tlast  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      lane = i % 4;
      w = 64'(cv[i].c16) << (16 * lane);
      i_tdata = w;
`ifdef CHDR_16SC_TO_8SC_ROUND_EN
      e32 = 32'(cv[i].exp_rnd) << (8 * lane);
`else
      e32 = 32'(cv[i].exp_trn) << (8 * lane);
`endif
      @(negedge clk);
      check($sformatf("conv%0d_%h", i, cv[i].c16), o_tdata, {e32, 32'h0});
      check($sformatf("conv%0d_last", i), 64'(o_tlast), 64'h1);
      @(posedge clk); #1;
    end
    o_tready = 1'b1;
    @(posedge clk); #1;
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    o_tready = 1'b0;
    @(negedge clk);
    check("odd_tail_debug", 64'(debug), 64'h0);

    // Directed packets: even, odd, timed, header-only, header+time only.
    pl = '{64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
    add_packet(64'h0000_0018_0001_0002, 64'h0, pl);
    pl = '{64'h7FF0_0180_FF80_8000, 64'h0100_0200_0300_0400, 64'hFFFF_8001_7FFF_0080};
    add_packet(64'h0000_0020_0003_0004, 64'h0, pl);
    pl = '{64'hAAAA_BBBB_CCCC_DDDD, 64'h0123_4567_89AB_CDEF};
    add_packet(64'h2000_0020_0005_0006, 64'hCAFE_F00D_1234_5678, pl);
    pl.delete();
    add_packet(64'h0000_0008_0007_0008, 64'h0, pl);
    add_packet(64'h2000_0010_0009_000A, 64'h0BAD_C0DE_0000_0001, pl);
    run_stream(1'b0);

    // Random packets with random stalls on both sides.
    for (int i = 0; i < 12; i++) add_random_packet();
    run_stream(1'b1);

    // Same with SID rewrite enabled.
    write_set(SET_BASE, 32'h0001_BEEF);
    m_sid_on = 1'b1;
    m_dest   = 16'hBEEF;
    for (int i = 0; i < 8; i++) add_random_packet();
    run_stream(1'b1);

    // Reset while a word is held in SECOND.
    p1 = 64'h7FF0_0180_FF80_8000;
    p2 = 64'h1234_ABCD_0000_FFFF;
    @(posedge clk); #1;
    i_tdata  = 64'h0000_0028_0000_0000;
    i_tlast  = 1'b0;
    i_tvalid = 1'b1;
    o_tready = 1'b1;
    @(posedge clk); #1;
    i_tdata = p1;
    @(posedge clk); #1;
    i_tdata  = p2;
    o_tready = 1'b0;
    @(negedge clk);
    check("second_debug", 64'(debug), 64'hB);
    check("second_data", o_tdata, {m_conv32(p1), m_conv32(p2)});
    reset = 1'b0;
    #1;
    check("midrst_debug", 64'(debug), 64'h0);
    m_sid_on = 1'b0;
    @(posedge clk); #1;
    reset    = 1'b1;
    i_tvalid = 1'b0;

    pl = '{64'h4000_3000_2000_1000, 64'hF000_E000_D000_C000, 64'h0080_0180_FF7F_7F80};
    add_packet(64'h0000_0020_1111_2222, 64'h0, pl);
    add_random_packet();
    run_stream(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/chdr_16sc_to_8sc.md
Name: chdr_16sc_to_8sc

Overview:
Streaming CHDR converter that narrows sc16 payload (16-bit I/Q) to sc8 (8-bit I/Q). Two 64-bit input payload lines are packed into one output line. It sits directly upstream of the sc8→sc16 expander and feeds the compressed-sample path that the expander consumes. The CHDR header length is rewritten. An optional SID destination rewrite is provided through a settings register.

Parameters:
BASE, 0, settings-bus address of the SID rewrite register

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
set_stb  in  1  settings bus strobe
set_addr  in  8  settings bus address
set_data  in  32  settings bus data
i_tdata  in  64  sc16 CHDR stream data
i_tlast  in  1  end of input packet
i_tvalid  in  1  input valid
i_tready  out  1  input ready
o_tdata  out  64  sc8 CHDR stream data
o_tlast  out  1  end of output packet
o_tvalid  out  1  output valid
o_tready  in  1  output ready
debug  out  32  {28'h0, hold_valid, 1'b0, state[1:0]}

Behaviour:
- Reset (reset low, asynchronous):
  - state=HEADER, hold register=0, hold_valid=0, settings register=0 (SID rewrite off).
  - Outputs follow combinationally from the inputs in state HEADER.
- Settings register at BASE, 17 bits: bit16=set_sid, bits[15:0]=new destination. Written on set_stb && set_addr==BASE.
- States: HEADER, TIME, FIRST, SECOND.
- HEADER:
  - o_tdata={i[63:48], new_len, sid_field}, where sid_field is {i[15:0], newdest} if set_sid, else i[31:0].
  - H=16 if i[61] else 8. P=i[47:32]-H. new_len=H+(P>>1), 16-bit wrap.
  - o_tvalid=i_tvalid, i_tready=o_tready, o_tlast=i_tlast.
  - On handshake: next state is HEADER if i_tlast, else TIME if i[61], else FIRST.
- TIME:
  - Line passes unchanged; valid, ready and last are forwarded directly.
  - On handshake: next state is HEADER if i_tlast, else FIRST.
- FIRST:
  - If !i_tlast: i_tready=1, o_tvalid=0. On i_tvalid, hold<=conv(i_tdata) (32 bits), hold_valid<=1, next state SECOND.
  - If i_tlast: o_tdata={conv(i_tdata), 32'h0}, o_tvalid=i_tvalid, i_tready=o_tready, o_tlast=1. On handshake, next state HEADER.
- SECOND:
  - o_tdata={hold, conv(i_tdata)}, o_tvalid=i_tvalid, i_tready=o_tready, o_tlast=i_tlast.
  - On handshake: hold_valid<=0; next state HEADER if i_tlast, else FIRST.
- conv(): maps 4 input components, each i[16k+15:16k], to output bytes in the same order. Each byte is c8=sat8(f(c16)):
  - With rounding: f=(c16+128)>>>8, 17-bit signed. sat8 clamps to [-128, 127].
  - Without rounding: f=c16[15:8], no saturation needed.
- Latency: zero cycles for emitted beats (combinational path). The FIRST half of a pair is absorbed in one cycle.
- Backpressure: o_tready low in SECOND or HEADER stalls the input. The hold register stays stable.
- Header-only packet (tlast on HEADER or TIME): one output line, back to HEADER.
- Input length not a multiple of 4 payload bytes is undefined; no error checking.
- Reset mid-packet: returns to HEADER and drops the hold register. Downstream sees a truncated packet without tlast; this is accepted.

Optional Feature:
- Macro: CHDR_16SC_TO_8SC_ROUND_EN.
- Defined: round-half-up plus saturation, as in conv().
- Undefined: plain truncation, c8=c16[15:8]. Adder and saturation logic are removed.

Decomposition:
- Shared package (chdr_pkg): CHDR field positions (length [47:32], has_time bit 61), header byte constants 8/16, and state encodings.
- One natural sub-module: sc16_to_sc8_sample. It is purely combinational, converts one 32-bit I/Q pair and contains the rounding/saturation logic; it is instantiated twice.
- Settings via the existing setting_reg.

Test Plan:
1. Even packet: header len=24, no time, 2 payload lines, o_tready=1.
   - Output 2 lines: len=16; then {hi-bytes line1, hi-bytes line2}; tlast on line 2.
2. Odd packet: len=32, 3 payload lines.
   - Output len=20, 3 lines; last line = {conv(line3), 32'h0} with tlast.
3. Timed packet: i[61]=1, len=32, 2 payload lines.
   - Output len=24; time line passes unchanged; then one packed line.
4. Rounding and saturation with ROUND_EN:
   - Components 7FF0→7F, 0180→02, FF80→00, 8000→80.
   - Without ROUND_EN: 7F, 01, FF, 80.
5. SID rewrite and backpressure:
   - Write set_data=0x1_ABCD at BASE; header low 32 bits become {i[15:0], ABCD}.
   - Toggle o_tready randomly; the output sequence is identical to the unstalled run.
6. Reset in SECOND:
   - Assert reset with a word held; state=HEADER and debug=0.
   - The next packet converts correctly.
